// File: rtl/imem_loader.sv
// Serial instruction-memory loader: takes a byte stream (2-byte word count, then
// little-endian 32-bit words), writes them to RAM from address 0, and holds the CPU in reset while loading.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clck,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
  // byte_ready is a register driven from the next state only, so it never
  // depends combinationally on byte_valid.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [16:0]       DEPTH_L  = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [7:0]          nlo_q;
  logic [15:0]         rem_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [1:0]          bidx_q;
  logic [23:0]         asm_q;

  logic                byte_ready_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                cpu_rst_n_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                xfer;
  logic [15:0]         hdr_n;
  logic                last_byte;

  assign xfer      = byte_valid && byte_ready_q;
  assign hdr_n     = {byte_data, nlo_q};
  assign last_byte = (bidx_q == 2'd3) && (rem_q == 16'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_HDR0;
      S_HDR0: if (xfer) state_d = S_HDR1;
      S_HDR1: begin
        if (xfer) begin
          if (hdr_n == 16'd0)                state_d = S_IDLE;
          else if ({1'b0, hdr_n} > DEPTH_L)  state_d = S_ERR;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: if (xfer && last_byte) state_d = S_FIN;
      // FIN is the cycle carrying the final write; the core stays in reset
      // and start is not honoured until IDLE is reached.
      S_FIN:  state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      state_q      <= S_IDLE;
      nlo_q        <= 8'd0;
      rem_q        <= 16'd0;
      waddr_q      <= '0;
      bidx_q       <= 2'd0;
      asm_q        <= 24'd0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
      busy_q       <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
      cpu_rst_n_q  <= (state_d == S_IDLE);
      err_q        <= (state_d == S_ERR);
      done_q       <= ((state_q == S_HDR1) && xfer && (hdr_n == 16'd0)) ||
                      ((state_q == S_DATA) && (state_d == S_FIN));
      wr_en_q      <= 1'b0;

      if ((state_q == S_HDR0) && xfer) begin
        nlo_q <= byte_data;
      end

      if ((state_q == S_HDR1) && xfer) begin
        rem_q   <= hdr_n;
        waddr_q <= '0;
        bidx_q  <= 2'd0;
      end

      if ((state_q == S_DATA) && xfer) begin
        bidx_q <= bidx_q + 2'd1;
        // First byte lands lowest: shift right, new byte enters at the top.
        asm_q  <= {byte_data, asm_q[23:8]};
        if (bidx_q == 2'd3) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= waddr_q;
          wr_data_q <= {byte_data, asm_q};
          waddr_q   <= waddr_q + ADDR_ONE;
          rem_q     <= rem_q - 16'd1;
        end
      end
    end
  end

  assign byte_ready  = byte_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed program loads scored against a
// queue of expected RAM writes built from the stream format.
module tb_imem_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int W      = ADDR_W + 32;

  logic              clck = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  prog[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clck        (clck),
    .rst         (rst),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clck = ~clck;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clck) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[W-1:32]));
          check("wr_data", 64'(wr_data), 64'(e[31:0]));
        end
      end
      if (done) done_cnt++;
      if (busy) check("cpu_rst_n_during_load", 64'(cpu_rst_n), 0);
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent;
    sent = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clck);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 200 && !sent; k++) begin
      if (byte_ready) sent = 1'b1;
      @(negedge clck);
    end
    byte_valid = 1'b0;
    if (!sent) check("byte_ready_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_byte_ready"}, 64'(byte_ready), 0);
    check({pfx, "_wr_en"},      64'(wr_en), 0);
    check({pfx, "_wr_addr"},    64'(wr_addr), 0);
    check({pfx, "_wr_data"},    64'(wr_data), 0);
    check({pfx, "_cpu_rst_n"},  64'(cpu_rst_n), 0);
    check({pfx, "_busy"},       64'(busy), 0);
    check({pfx, "_done"},       64'(done), 0);
    check({pfx, "_err"},        64'(err), 0);
  endtask

  task automatic do_reset(input string pfx);
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clck);
    check_reset_vals(pfx);
    rst = 1'b0;
    @(negedge clck);
    check({pfx, "_cpu_rst_n_release"}, 64'(cpu_rst_n), 1);
  endtask

  // One load of n words taken from prog[]; model: word i goes to address i.
  task automatic run_load(input int n, input int gmin, input int gmax, input bit poke_start);
    logic [15:0] nh;
    logic [31:0] w;
    int d0;
    nh = n[15:0];
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clck);
    start = 1'b0;
    check("start_busy", 64'(busy), 1);
    check("start_ready", 64'(byte_ready), 1);
    check("start_cpu_rst_n", 64'(cpu_rst_n), 0);
    send_byte(nh[7:0],  $urandom_range(gmax, gmin));
    send_byte(nh[15:8], $urandom_range(gmax, gmin));
    if (n == 0) begin
      check("empty_done", 64'(done), 1);
      check("empty_busy", 64'(busy), 0);
      check("empty_wr_en", 64'(wr_en), 0);
      @(negedge clck);
      check("empty_cpu_rst_n", 64'(cpu_rst_n), 1);
      check("empty_done_count", 64'(done_cnt - d0), 1);
    end else if (n > DEPTH) begin
      check("oversize_err", 64'(err), 1);
      check("oversize_ready", 64'(byte_ready), 0);
      check("oversize_cpu_rst_n", 64'(cpu_rst_n), 0);
      check("oversize_busy", 64'(busy), 0);
      byte_valid = 1'b1;
      byte_data  = 8'h5a;
      for (int k = 0; k < 6; k++) begin
        start = k[0];
        @(negedge clck);
        check("oversize_hold_err", 64'(err), 1);
        check("oversize_hold_ready", 64'(byte_ready), 0);
        check("oversize_hold_cpu_rst_n", 64'(cpu_rst_n), 0);
      end
      start = 1'b0;
      byte_valid = 1'b0;
      check("oversize_no_done", 64'(done_cnt - d0), 0);
      do_reset("oversize_rst");
    end else begin
      for (int i = 0; i < n; i++) begin
        w = prog[i];
        exp_q.push_back({i[ADDR_W-1:0], w});
        for (int b = 0; b < 4; b++) begin
          if (poke_start && i == 0 && b == 2) begin
            start = 1'b1;
            @(negedge clck);
            start = 1'b0;
            check("poke_busy", 64'(busy), 1);
            check("poke_ready", 64'(byte_ready), 1);
          end
          send_byte(w[8*b +: 8], $urandom_range(gmax, gmin));
        end
      end
      // Now in the final write cycle; start here must be ignored.
      check("final_wr_en", 64'(wr_en), 1);
      check("final_done", 64'(done), 1);
      check("final_ready", 64'(byte_ready), 0);
      check("final_cpu_rst_n", 64'(cpu_rst_n), 0);
      start = 1'b1;
      @(negedge clck);
      start = 1'b0;
      check("after_busy", 64'(busy), 0);
      check("after_cpu_rst_n", 64'(cpu_rst_n), 1);
      check("after_done", 64'(done), 0);
      check("after_ready", 64'(byte_ready), 0);
      check("after_exp_empty", 64'(exp_q.size()), 0);
      check("done_count", 64'(done_cnt - d0), 1);
      repeat (2) @(negedge clck);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clck);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clck);
    check("reset_cpu_rst_n_rise", 64'(cpu_rst_n), 1);
    check("reset_idle_busy", 64'(busy), 0);

    // normal load, full rate
    prog = '{32'h00100513, 32'h00100073};
    run_load(2, 0, 0, 1'b0);

    // same program with 3-cycle stalls between bytes
    run_load(2, 3, 3, 1'b0);

    // empty program
    run_load(0, 0, 0, 1'b0);

    // oversize header, recovered by reset
    run_load(DEPTH + 1, 0, 0, 1'b0);

    // reset mid-word, then reload one word
    start = 1'b1;
    @(negedge clck);
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    do_reset("midword_rst");
    check("midword_no_write", 64'(exp_q.size()), 0);
    prog = '{32'hDDCCBBAA};
    run_load(1, 0, 0, 1'b0);

    // start pulsed mid-DATA
    prog = '{32'hCAFEF00D, 32'h12345678, 32'h0BADBEEF};
    run_load(3, 0, 2, 1'b1);

    // randomized loads
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(6, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      run_load(n, 0, $urandom_range(3, 0), r[0]);
    end

    // largest legal program, full rate
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    run_load(DEPTH, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
